// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: EX-stage branch/jump redirect sequencing with pending replay while IMEM is busy
// Ports: CLK/RESET (async, active-high); BRANCH_SEL, B_PC, EX_VALID from EX; IMEM_BUSY, LOAD_USE, MUL_BUSY hazards;
//        PC_SEL/PC_TARGET/PC_WRITE drive the PC; IFID_/IDEX_ WRITE and FLUSH drive pipeline registers;
//        REDIRECT_CNT is a saturating redirect count, present only when BJ_PERF_CNT_EN is defined (else tied to 0).
module branch_redirect_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             BRANCH_SEL,
   input  logic [31:0]      B_PC,
   input  logic             EX_VALID,
   input  logic             IMEM_BUSY,
   input  logic             LOAD_USE,
   input  logic             MUL_BUSY,
   output logic             PC_SEL,
   output logic [31:0]      PC_TARGET,
   output logic             PC_WRITE,
   output logic             IFID_WRITE,
   output logic             IDEX_WRITE,
   output logic             IFID_FLUSH,
   output logic             IDEX_FLUSH,
   output logic [CNT_W-1:0] REDIRECT_CNT
);
   typedef enum logic {RUN, PEND} state_t;
   state_t state, state_nxt;
   logic [31:0] pend_target, tgt;
   logic take, sel, pw, fw, dw, ff, df;
   assign take = BRANCH_SEL & EX_VALID & ~MUL_BUSY;
   // A held redirect and a fresh taken branch share one shape: flush both stages, issue only when IMEM accepts.
   always_comb begin
      state_nxt = state;
      sel = 1'b0;
      tgt = B_PC;
      pw = 1'b1;
      fw = 1'b1;
      dw = 1'b1;
      ff = 1'b0;
      df = 1'b0;
      if (state == PEND || take) begin
         tgt = (state == PEND) ? pend_target : B_PC;
         sel = ~IMEM_BUSY;
         pw = ~IMEM_BUSY;
         ff = 1'b1;
         df = 1'b1;
         state_nxt = IMEM_BUSY ? PEND : RUN;
      end else if (MUL_BUSY) begin
         pw = 1'b0;
         fw = 1'b0;
         dw = 1'b0;
      end else if (LOAD_USE) begin
         pw = 1'b0;
         fw = 1'b0;
         df = 1'b1;
      end
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= RUN;
         pend_target <= '0;
      end else begin
         state <= state_nxt;
         if (state == RUN && take && IMEM_BUSY) pend_target <= B_PC;
      end
   end
   assign PC_SEL = ~RESET & sel;
   assign PC_TARGET = RESET ? '0 : tgt;
   assign PC_WRITE = ~RESET & pw;
   assign IFID_WRITE = ~RESET & fw;
   assign IDEX_WRITE = ~RESET & dw;
   assign IFID_FLUSH = ~RESET & ff;
   assign IDEX_FLUSH = ~RESET & df;
`ifdef BJ_PERF_CNT_EN
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) cnt <= '0;
      else if (sel && pw && cnt != '1) cnt <= cnt + 1'b1;
   end
   assign REDIRECT_CNT = RESET ? '0 : cnt;
`else
   assign REDIRECT_CNT = '0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: scoreboard bench for branch_redirect_ctrl with a small reference model
module tb_branch_redirect_ctrl;
   logic clk = 1'b0, rst = 1'b0;
   logic bs = 1'b0, ev = 1'b0, ib = 1'b0, lu = 1'b0, mb = 1'b0;
   logic [31:0] bpc = '0;
   logic pc_sel, pc_write, ifid_write, idex_write, ifid_flush, idex_flush;
   logic [31:0] pc_target;
   logic [1:0] redirect_cnt;
   typedef struct packed {
      logic sel;
      logic [31:0] tgt;
      logic pw, fw, dw, ff, df;
      logic [1:0] cnt;
   } exp_t;
   exp_t sb[$];
   int n_chk = 0, n_pass = 0;
   logic m_pend = 1'b0;
   logic [31:0] m_tgt = '0;
   logic [1:0] m_cnt = '0;
   branch_redirect_ctrl #(.CNT_W(2)) dut (
      .CLK(clk), .RESET(rst), .BRANCH_SEL(bs), .B_PC(bpc), .EX_VALID(ev),
      .IMEM_BUSY(ib), .LOAD_USE(lu), .MUL_BUSY(mb),
      .PC_SEL(pc_sel), .PC_TARGET(pc_target), .PC_WRITE(pc_write),
      .IFID_WRITE(ifid_write), .IDEX_WRITE(idex_write),
      .IFID_FLUSH(ifid_flush), .IDEX_FLUSH(idex_flush), .REDIRECT_CNT(redirect_cnt)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask
   task automatic compare(input string tag);
      exp_t e;
      e = sb.pop_front();
      check({tag, ".pc_sel"}, {31'b0, pc_sel}, {31'b0, e.sel});
      check({tag, ".pc_target"}, pc_target, e.tgt);
      check({tag, ".pc_write"}, {31'b0, pc_write}, {31'b0, e.pw});
      check({tag, ".ifid_write"}, {31'b0, ifid_write}, {31'b0, e.fw});
      check({tag, ".idex_write"}, {31'b0, idex_write}, {31'b0, e.dw});
      check({tag, ".ifid_flush"}, {31'b0, ifid_flush}, {31'b0, e.ff});
      check({tag, ".idex_flush"}, {31'b0, idex_flush}, {31'b0, e.df});
      check({tag, ".cnt"}, {30'b0, redirect_cnt}, {30'b0, e.cnt});
   endtask
   function automatic logic [1:0] cnt_view();
`ifdef BJ_PERF_CNT_EN
      return m_cnt;
`else
      return 2'd0;
`endif
   endfunction
   // Called mid-cycle; checks the asynchronous zeroing, then releases just after the next edge.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      sb.push_back('0);
      compare(tag);
      m_pend = 1'b0;
      m_tgt = '0;
      m_cnt = '0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask
   // Called at posedge+1: drive, predict, compare at negedge, advance model over the next edge.
   task automatic step(input string tag, input logic b, input logic [31:0] pc, input logic v,
                       input logic busy, input logic l, input logic m);
      exp_t e;
      logic take;
      bs = b; bpc = pc; ev = v; ib = busy; lu = l; mb = m;
      take = b & v & ~m;
      e = '0;
      e.cnt = cnt_view();
      e.tgt = pc;
      if (m_pend) begin
         e.tgt = m_tgt;
         e.sel = ~busy; e.pw = ~busy; e.fw = 1; e.dw = 1; e.ff = 1; e.df = 1;
         m_pend = busy;
      end else if (take) begin
         e.sel = ~busy; e.pw = ~busy; e.fw = 1; e.dw = 1; e.ff = 1; e.df = 1;
         if (busy) begin m_pend = 1'b1; m_tgt = pc; end
      end else if (m) begin
         e.pw = 0; e.fw = 0; e.dw = 0;
      end else if (l) begin
         e.pw = 0; e.fw = 0; e.dw = 1; e.df = 1;
      end else begin
         e.pw = 1; e.fw = 1; e.dw = 1;
      end
      if (e.sel && e.pw && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
      sb.push_back(e);
      @(negedge clk);
      compare(tag);
      @(posedge clk);
      #1;
   endtask
   initial begin
      #3;
      do_reset("reset");
      step("idle", 0, 32'h0, 0, 0, 0, 0);
      step("redir", 1, 32'h100, 1, 0, 0, 0);
      step("after_redir", 0, 32'h0, 0, 0, 0, 0);
      step("pend1", 1, 32'h200, 1, 1, 0, 0);
      step("pend2", 1, 32'h0, 1, 1, 1, 1);
      step("pend3", 0, 32'h0, 0, 1, 0, 0);
      step("pend_issue", 0, 32'h0, 0, 0, 0, 0);
      step("after_pend", 0, 32'h0, 0, 0, 0, 0);
      step("load_use", 0, 32'h0, 0, 0, 1, 0);
      step("lu_branch", 1, 32'h300, 1, 0, 1, 0);
      step("mul_mask", 1, 32'h500, 1, 0, 0, 1);
      step("mul_lu", 0, 32'h0, 0, 0, 1, 1);
      step("no_valid", 1, 32'h600, 0, 0, 0, 0);
      step("enter_pend", 1, 32'h400, 1, 1, 0, 0);
      do_reset("reset_pend");
      step("post_reset", 0, 32'h0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("sat", 1, 32'h1000 + 32'(i * 4), 1, 0, 0, 0);
      step("sat_hold", 0, 32'h0, 0, 0, 0, 0);
      step("odd_target", 1, 32'hffff_fffe, 1, 0, 0, 0);
      for (int i = 0; i < 60; i++)
         step("rand", 1'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
